// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
interface fetch_stage_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_data,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_data,
        output imem_valid
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory requests,
// and loads the fetch/decode register consumed by decode.
//
// state  | meaning
// FETCH  | requesting the word at pc, accepting it when imem_valid
// DRAIN  | redirect pending; waiting out a stale miss before jumping to target
// HALTED | HLT fetched; no requests until flush or rst
module fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] NOP_INSTR  = 16'hE000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic [15:0]        branch_pc,
    fetch_stage_if.master      bus,
    output logic [15:0]        curr_pc_fd,
    output logic [15:0]        curr_instr_fd,
    output logic               valid_fd,
    output logic               halted,
    output logic               fetch_busy
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [15:0] pc, pc_n;
    logic [15:0] target, target_n;
    logic [15:0] pc_fd_n, instr_fd_n;
    logic        valid_fd_n;
    logic [15:0] branch_al;

    // Redirect targets are forced to halfword alignment.
    assign branch_al = {branch_pc[15:1], 1'b0};

    // Request side is combinational so a new pc is presented the cycle it loads.
    assign bus.imem_req  = (state != HALTED) && !rst;
    assign bus.imem_addr = pc;
    assign fetch_busy    = bus.imem_req && !bus.imem_valid;
    assign halted        = (state == HALTED);

    // State, PC, redirect target and fetch/decode register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            target        <= 16'h0000;
            curr_pc_fd    <= 16'h0000;
            curr_instr_fd <= NOP_INSTR;
            valid_fd      <= 1'b0;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            target        <= target_n;
            curr_pc_fd    <= pc_fd_n;
            curr_instr_fd <= instr_fd_n;
            valid_fd      <= valid_fd_n;
        end
    end

    // Next-state logic; flush outranks stall, which outranks normal fetch.
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        target_n   = target;
        pc_fd_n    = curr_pc_fd;
        instr_fd_n = curr_instr_fd;
        valid_fd_n = valid_fd;

        case (state)
            FETCH: begin
                if (flush) begin
                    pc_fd_n    = 16'h0000;
                    instr_fd_n = NOP_INSTR;
                    valid_fd_n = 1'b0;
                    if (bus.imem_valid) begin
                        pc_n = branch_al;
                    end else begin
                        target_n = branch_al;
                        state_n  = DRAIN;
                    end
                end else if (!stall) begin
                    if (bus.imem_valid) begin
                        pc_fd_n    = pc;
                        instr_fd_n = bus.imem_data;
                        valid_fd_n = 1'b1;
                        if (bus.imem_data[15:12] == HLT_OPCODE) begin
                            state_n = HALTED;
                        end else begin
                            pc_n = pc + 16'd2;
                        end
                    end else begin
                        pc_fd_n    = 16'h0000;
                        instr_fd_n = NOP_INSTR;
                        valid_fd_n = 1'b0;
                    end
                end
            end

            DRAIN: begin
                if (flush) begin
                    target_n = branch_al;
                end
                if (flush || !stall) begin
                    pc_fd_n    = 16'h0000;
                    instr_fd_n = NOP_INSTR;
                    valid_fd_n = 1'b0;
                end
                // The stale word is dropped; the newest redirect wins.
                if (bus.imem_valid) begin
                    pc_n    = flush ? branch_al : target;
                    state_n = FETCH;
                end
            end

            HALTED: begin
                if (flush) begin
                    pc_n    = branch_pc;
                    state_n = FETCH;
                end
                if (flush || !stall) begin
                    pc_fd_n    = 16'h0000;
                    instr_fd_n = NOP_INSTR;
                    valid_fd_n = 1'b0;
                end
            end

            default: begin
                state_n = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [15:0] branch_pc;
    logic [15:0] curr_pc_fd;
    logic [15:0] curr_instr_fd;
    logic        valid_fd;
    logic        halted;
    logic        fetch_busy;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .branch_pc     (branch_pc),
        .bus           (bus),
        .curr_pc_fd    (curr_pc_fd),
        .curr_instr_fd (curr_instr_fd),
        .valid_fd      (valid_fd),
        .halted        (halted),
        .fetch_busy    (fetch_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic [15:0] bpc;
        logic        valid;
        logic [15:0] data;
        logic        e_req;
        logic        e_busy;
        logic [15:0] e_addr;
        logic [15:0] e_pcfd;
        logic [15:0] e_instr;
        logic        e_vfd;
        logic        e_halt;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(logic r, logic s, logic f, logic [15:0] bpc,
                                logic v, logic [15:0] d, logic ereq, logic ebusy,
                                logic [15:0] eaddr, logic [15:0] epc,
                                logic [15:0] ein, logic evfd, logic eh);
        vec_t t;
        t.rst = r; t.stall = s; t.flush = f; t.bpc = bpc; t.valid = v; t.data = d;
        t.e_req = ereq; t.e_busy = ebusy; t.e_addr = eaddr; t.e_pcfd = epc;
        t.e_instr = ein; t.e_vfd = evfd; t.e_halt = eh;
        return t;
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check combinational outputs, then
    // registered outputs just after the rising edge.
    task automatic run_vec(vec_t t, int idx);
        @(negedge clk);
        rst            = t.rst;
        stall          = t.stall;
        flush          = t.flush;
        branch_pc      = t.bpc;
        bus.imem_valid = t.valid;
        bus.imem_data  = t.data;
        #1;
        chk($sformatf("v%0d imem_req", idx), {15'd0, bus.imem_req}, {15'd0, t.e_req});
        chk($sformatf("v%0d fetch_busy", idx), {15'd0, fetch_busy}, {15'd0, t.e_busy});
        if (t.e_req) chk($sformatf("v%0d imem_addr", idx), bus.imem_addr, t.e_addr);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d curr_pc_fd", idx), curr_pc_fd, t.e_pcfd);
        chk($sformatf("v%0d curr_instr_fd", idx), curr_instr_fd, t.e_instr);
        chk($sformatf("v%0d valid_fd", idx), {15'd0, valid_fd}, {15'd0, t.e_vfd});
        chk($sformatf("v%0d halted", idx), {15'd0, halted}, {15'd0, t.e_halt});
    endtask

    initial begin
        int bubbles;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_pc = 16'h0;
        bus.imem_valid = 1'b0; bus.imem_data = 16'h0;

        //             rst stl fl  bpc      v  data     req bsy addr     pcfd     instr    vfd hlt
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hE000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h1123, 1, 0, 16'h0000, 16'h0000, 16'h1123, 1, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h2456, 1, 0, 16'h0002, 16'h0002, 16'h2456, 1, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h3789, 1, 0, 16'h0004, 16'h0002, 16'h2456, 1, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 1, 16'h3789, 1, 0, 16'h0004, 16'h0002, 16'h2456, 1, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h3789, 1, 0, 16'h0004, 16'h0004, 16'h3789, 1, 0));
        // flush to 0x0040 while pc=6 misses for 3 cycles
        vecs.push_back(mk(0, 0, 1, 16'h0040, 0, 16'h0000, 1, 1, 16'h0006, 16'h0000, 16'hE000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0006, 16'h0000, 16'hE000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0006, 16'h0000, 16'hE000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h4444, 1, 0, 16'h0006, 16'h0000, 16'hE000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h5040, 1, 0, 16'h0040, 16'h0040, 16'h5040, 1, 0));
        // double redirect in one drain, second target odd to exercise alignment
        vecs.push_back(mk(0, 0, 1, 16'h0040, 0, 16'h0000, 1, 1, 16'h0042, 16'h0000, 16'hE000, 0, 0));
        vecs.push_back(mk(0, 0, 1, 16'h0081, 0, 16'h0000, 1, 1, 16'h0042, 16'h0000, 16'hE000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h1111, 1, 0, 16'h0042, 16'h0000, 16'hE000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h6080, 1, 0, 16'h0080, 16'h0080, 16'h6080, 1, 0));
        // flush with a hit: word discarded, redirect next cycle
        vecs.push_back(mk(0, 0, 1, 16'h0008, 1, 16'h7777, 1, 0, 16'h0082, 16'h0000, 16'hE000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h1008, 1, 0, 16'h0008, 16'h0008, 16'h1008, 1, 0));
        // HLT at 0x000A, then wake via flush to 0x0020
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'hF000, 1, 0, 16'h000A, 16'h000A, 16'hF000, 1, 1));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hE000, 0, 1));
        vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hE000, 0, 1));
        vecs.push_back(mk(0, 0, 1, 16'h0020, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hE000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h2020, 1, 0, 16'h0020, 16'h0020, 16'h2020, 1, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0022, 16'h0000, 16'hE000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h3022, 1, 0, 16'h0022, 16'h0022, 16'h3022, 1, 0));
        // wrap at 0xFFFE, then reset during a miss
        vecs.push_back(mk(0, 0, 1, 16'hFFFE, 1, 16'h0000, 1, 0, 16'h0024, 16'h0000, 16'hE000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h1FFE, 1, 0, 16'hFFFE, 16'hFFFE, 16'h1FFE, 1, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0000, 16'h0000, 16'hE000, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hE000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h4000, 1, 0, 16'h0000, 16'h0000, 16'h4000, 1, 0));
        // reset while draining must return to FETCH at RESET_PC
        vecs.push_back(mk(0, 0, 1, 16'h0010, 0, 16'h0000, 1, 1, 16'h0002, 16'h0000, 16'hE000, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hE000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h5000, 1, 0, 16'h0000, 16'h0000, 16'h5000, 1, 0));

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Hand sequence: 4-cycle miss at pc=2 yields exactly 4 bubbles, then the word.
        bubbles = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            rst = 1'b0; stall = 1'b0; flush = 1'b0; bus.imem_valid = 1'b0;
            #1;
            chk("miss imem_addr", bus.imem_addr, 16'h0002);
            @(posedge clk);
            #1;
            if (!valid_fd && curr_instr_fd == 16'hE000) bubbles++;
        end
        chk("miss bubble count", 16'(bubbles), 16'd4);
        @(negedge clk);
        bus.imem_valid = 1'b1; bus.imem_data = 16'h6002;
        @(posedge clk);
        #1;
        chk("miss word pc", curr_pc_fd, 16'h0002);
        chk("miss word instr", curr_instr_fd, 16'h6002);
        @(negedge clk);
        #1;
        chk("miss next addr", bus.imem_addr, 16'h0004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined processor, directly upstream of the decode stage. Owns the program counter, drives the instruction-memory request, and loads the fetch/decode pipeline register (`curr_pc_fd`, `curr_instr_fd`) that decode consumes. Honours decode's load-use `stall` and branch `flush` and redirects to `branch_pc`. Stops fetching on HLT and handles memory responses that arrive over multiple cycles.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset
- `NOP_INSTR`, 16'hE000, bubble instruction (PCS $0) inserted into the fetch/decode register
- `HLT_OPCODE`, 4'hF, opcode (bits [15:12]) that halts fetch
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `stall` in 1: decode hazard stall; hold the PC and the fetch/decode register
- `flush` in 1: decode resolved a taken branch; discard the younger fetch and redirect
- `branch_pc` in 16: redirect target, valid when `flush`=1
- `imem_req` out 1: fetch request to instruction memory
- `imem_addr` out 16: fetch address, equal to PC (or the drained address)
- `imem_data` in 16: instruction word
- `imem_valid` in 1: level signal, high while `imem_data` holds the word for `imem_addr` and `imem_req` is high
- `curr_pc_fd` out 16: registered address of the instruction in the fetch/decode register
- `curr_instr_fd` out 16: registered instruction to decode
- `valid_fd` out 1: registered flag, 1 = real instruction, 0 = bubble
- `halted` out 1: state is HALTED
- `fetch_busy` out 1: `imem_req & ~imem_valid` (miss in progress)

## Operation
- State machine has three states: FETCH, DRAIN, HALTED. Registers are `pc`, `target`, and the fetch/decode register (`curr_pc_fd`, `curr_instr_fd`, `valid_fd`).
- Priority within a cycle, highest first: `rst`, then `flush`, then `stall`, then normal operation.
- Request: `imem_req`=1 in FETCH and DRAIN, 0 in HALTED and while `rst`=1.
  - `imem_addr`=`pc` in FETCH and DRAIN. `pc` does not change while a request is outstanding.
- FETCH, `flush`=1:
  - The fetch/decode register loads {0, `NOP_INSTR`, 0}.
  - If `imem_valid`=1: discard the word, set `pc` to `{branch_pc[15:1],1'b0}`, stay in FETCH.
  - If `imem_valid`=0: set `target` to `{branch_pc[15:1],1'b0}`, go to DRAIN.
- FETCH, `stall`=1: hold `pc` and the fetch/decode register. `imem_req` stays high, so memory keeps `imem_valid`/`imem_data`.
- FETCH, normal, `imem_valid`=1:
  - The fetch/decode register loads {`pc`, `imem_data`, 1}.
  - If `imem_data[15:12]`==`HLT_OPCODE`: hold `pc` and go to HALTED.
  - Otherwise: `pc` <= `pc`+2, modulo 2^16, so 16'hFFFE wraps to 16'h0000.
- FETCH, normal, `imem_valid`=0: the fetch/decode register loads the bubble {0, `NOP_INSTR`, 0}; `pc` holds.
- DRAIN keeps the stale request alive until memory completes it, because the address must not change mid-miss.
  - `flush`=1: `target` updates to the new `branch_pc`; the newest redirect wins. If `imem_valid`=1 in the same cycle, `pc` loads the new `branch_pc` directly.
  - `imem_valid`=1: discard the word, `pc` <= `target`, go to FETCH.
  - The fetch/decode register loads the bubble unless `stall`=1, in which case it holds.
- HALTED:
  - `flush`=1 (an older taken branch whose HLT was speculatively fetched): `pc` <= `branch_pc`, go to FETCH, load the bubble.
  - Otherwise: load the bubble when `stall`=0, hold when `stall`=1.
  - Leave HALTED only via `flush` or `rst`.
- Reset values: `pc`=`RESET_PC`, state=FETCH, `target`=0, `curr_pc_fd`=0, `curr_instr_fd`=`NOP_INSTR`, `valid_fd`=0, `halted`=0, `imem_req`=0.
- A reset mid-miss abandons the outstanding request. Memory must accept the address change when `rst` is asserted.

## Timing
- Memory is sampled at cycle n (`imem_valid`=1); the word appears on `curr_instr_fd` at n+1.
- With zero-wait memory, throughput is one instruction per cycle.
- Miss of k cycles (`imem_valid` low k cycles): k bubbles enter decode.
- Redirect with `flush` at cycle n and `imem_valid`=1: `imem_addr`=`branch_pc` at n+1.
- Redirect in DRAIN: `imem_addr`=`target` in the cycle after the stale `imem_valid`.
- `halted` rises in the cycle after the HLT word is accepted. HLT itself is in the fetch/decode register with `valid_fd`=1 that same cycle.
- `imem_req`, `imem_addr` and `fetch_busy` are combinational from state, `pc` and `imem_valid`. All other outputs are registered.

## Test plan
- Zero-wait memory, words 0x1123, 0x2456, 0x3789 at 0, 2, 4 after reset -> `curr_pc_fd`/`curr_instr_fd` show 0/1123, 2/2456, 4/3789 on consecutive cycles with `valid_fd`=1.
- `stall`=1 for 2 cycles while `curr_instr_fd`=0x2456 -> register and `imem_addr`=4 hold 2 cycles, then 0x3789 follows with no loss or duplication.
- `flush`=1 with `branch_pc`=0x0040 while PC=6 is a 3-cycle miss -> DRAIN; after the stale valid, `imem_addr`=0x0040; decode sees only bubbles (`valid_fd`=0, 0xE000) until the word at 0x0040.
- `flush` at 0x0040 then again at 0x0080 during the same drain -> next fetched address is 0x0080.
- Word 0xF000 at 0x000A -> `curr_instr_fd`=0xF000, `halted`=1 next cycle, `imem_req`=0; a later `flush` with `branch_pc`=0x0020 -> `halted`=0, fetch resumes at 0x0020.
- PC at 0xFFFE with non-HLT word -> next `imem_addr`=0x0000. `rst` mid-miss -> `imem_addr`=`RESET_PC`, `valid_fd`=0, `curr_instr_fd`=0xE000.
